array_scan_sequencer: RTL and testbench
=======================================

ARRAY_SCAN_SEQUENCER -- requirements
Module: array_scan_sequencer

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, heap element, key, array-number and result width (W).
REQ-002 SHALL have parameter NArea, default 3, elements per array area on the heap.
REQ-003 SHALL have parameter NArrays, default 4, number of valid array numbers.
REQ-004 SHALL have ports: clock  in  1  single clock, all state changes on posedge.
REQ-005 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-006 SHALL have ports, for requester n in {0,1}: reqN_valid in 1; reqN_ready out 1; reqN_op in 2 (0 arrayIndex, 1 arrayCountLess, 2 arrayCountGreater, 3 reserved); reqN_array in W; reqN_key in W.
REQ-007 SHALL have ports: res_valid out 1; res_ready in 1; res_data out W; res_owner out 1 (requester number); res_error out 1.
REQ-008 SHALL have ports: size_array out W; size_data in W, combinational array-size lookup, valid in the same cycle.
REQ-009 SHALL have ports: heap_rd out 1; heap_addr out W; heap_data in W, valid in the cycle after heap_rd.
REQ-010 SHALL have ports: busy out 1, high in every state except IDLE.

Function
REQ-011 SHALL share one heap read port between two requesters, running one scan at a time.
REQ-012 SHALL use FSM states IDLE, SIZE, SCAN, FLUSH and DONE.
REQ-013 SHALL assert reqN_ready only in IDLE, and only for the granted requester.
REQ-014 SHALL accept a request on the edge where valid&ready are both high, latching op, array, key and owner.
REQ-015 SHALL arbitrate round-robin: when both requesters are valid, the grant goes to the priority pointer; after each accept, the pointer moves to the other requester; a lone valid requester is granted regardless of pointer.
REQ-016 SHALL, in SIZE (one cycle), drive size_array with the latched array and set k = min(size_data, NArea).
REQ-017 SHALL, in SIZE, force k=0 and set res_error if array >= NArrays or op==3; result is then 0.
REQ-018 SHALL, in SCAN, last exactly k cycles, with heap_rd=1 and heap_addr = array*NArea + i for i = 0..k-1 in order.
REQ-019 SHALL go from SIZE directly to FLUSH when k=0.
REQ-020 SHALL, for each heap_data returned, accumulate as follows: op0 sets result to i+1 when the element equals key (last match wins); op1 increments when element < key; op2 increments when element > key.
REQ-021 SHALL perform all compares unsigned, W bits wide.
REQ-022 SHALL, in FLUSH (one cycle), absorb the final read data, then enter DONE.
REQ-023 SHALL hold res_valid=1 in DONE, with res_data/res_owner/res_error stable until res_ready.
REQ-024 SHALL return to IDLE on the edge where res_valid&res_ready are both high; a new request can be accepted from the next cycle.
REQ-025 SHALL provide fixed latency: with acceptance in cycle 0, res_valid first rises in cycle k+3 (k=3 gives cycle 6; k=0 gives cycle 3).
REQ-026 SHALL hold heap_rd=0 outside SCAN; heap_addr is don't-care when heap_rd=0.
REQ-027 SHALL ignore request inputs while busy; requesters hold valid and payload until ready.

Reset
REQ-028 SHALL, on reset high at a posedge, set: state IDLE, priority pointer to requester 0, res_valid=0, res_data=0, res_owner=0, res_error=0, heap_rd=0, busy=0, both ready outputs 0 in the reset cycle.
REQ-029 SHALL, on reset in any non-IDLE state, abandon the scan with no result and no further heap reads; it accepts again in the first cycle after reset deasserts.

Verification
REQ-030 SHALL verify: array 0 = [10,20,30], size 3; requester 0 arrayIndex keys 30, 20, 10, 15 -> results 3, 2, 1, 0, each res_valid 6 cycles after accept.
REQ-031 SHALL verify: same array; arrayCountLess keys 35, 25, 15, 5 -> 3, 2, 1, 0; arrayCountGreater keys 35, 25, 15, 5 -> 0, 1, 2, 3.
REQ-032 SHALL verify: both requesters valid continuously from reset -> grants alternate 0, 1, 0, 1, with res_owner matching; heap_addr sequence 0, 1, 2 per scan.
REQ-033 SHALL verify: size_data=0, or array=4 with NArrays=4, or op=3 -> res_data=0 and res_valid 3 cycles after accept, with no heap_rd; res_error=1 for the array=4 and op=3 cases only.
REQ-034 SHALL verify: size_data=7 with NArea=3 -> exactly 3 heap reads; res_ready held low 5 cycles -> res_valid and res_data stable throughout.
REQ-035 SHALL verify: reset asserted mid-SCAN -> next cycle heap_rd=0, res_valid=0, busy=0; a following request completes correctly.

Source files
------------

// File: rtl/array_scan_sequencer_if.sv
// Request, result, size-lookup and heap-read signals of the array scan sequencer.
// master: the sequencer itself; slave: the requesters, result sink, size table and heap.
interface array_scan_sequencer_if #(
  parameter int W = 12
);
  logic         req0_valid;
  logic         req0_ready;
  logic [1:0]   req0_op;
  logic [W-1:0] req0_array;
  logic [W-1:0] req0_key;
  logic         req1_valid;
  logic         req1_ready;
  logic [1:0]   req1_op;
  logic [W-1:0] req1_array;
  logic [W-1:0] req1_key;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_owner;
  logic         res_error;
  logic [W-1:0] size_array;
  logic [W-1:0] size_data;
  logic         heap_rd;
  logic [W-1:0] heap_addr;
  logic [W-1:0] heap_data;
  logic         busy;

  modport master (
    input  req0_valid, req0_op, req0_array, req0_key,
    input  req1_valid, req1_op, req1_array, req1_key,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_owner, res_error,
    input  res_ready,
    output size_array, input size_data,
    output heap_rd, heap_addr, input heap_data,
    output busy
  );

  modport slave (
    output req0_valid, req0_op, req0_array, req0_key,
    output req1_valid, req1_op, req1_array, req1_key,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_owner, res_error,
    output res_ready,
    input  size_array, output size_data,
    input  heap_rd, heap_addr, output heap_data,
    input  busy
  );
endinterface

// File: rtl/array_scan_sequencer.sv
// Round-robin shared heap scanner: arrayIndex / arrayCountLess / arrayCountGreater
// over one array area, one scan at a time, fixed latency k+3 from accept to result.
module array_scan_sequencer #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 3,
  parameter int NArrays            = 4
) (
  input logic                   clock,
  input logic                   reset,
  array_scan_sequencer_if.master bus
);
  localparam int W = MemoryElementWidth;
  localparam logic [W-1:0] NAREA_W   = W'(NArea);
  localparam logic [W-1:0] NARRAYS_W = W'(NArrays);

  typedef enum logic [2:0] {IDLE, SIZE, SCAN, FLUSH, DONE} state_e;

  state_e       state_q, state_d;
  logic         prio_q, prio_d;
  logic         owner_q, owner_d;
  logic [1:0]   op_q, op_d;
  logic [W-1:0] array_q, array_d;
  logic [W-1:0] key_q, key_d;
  logic         err_q, err_d;
  logic [W-1:0] k_q, k_d;
  logic [W-1:0] i_q, i_d;
  logic         pend_q, pend_d;
  logic [W-1:0] pidx_q, pidx_d;
  logic [W-1:0] result_q, result_d;

  logic grant;
  logic idle_ok;
  logic accept;
  logic bad_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      op_q     <= '0;
      array_q  <= '0;
      key_q    <= '0;
      err_q    <= 1'b0;
      k_q      <= '0;
      i_q      <= '0;
      pend_q   <= 1'b0;
      pidx_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      array_q  <= array_d;
      key_q    <= key_d;
      err_q    <= err_d;
      k_q      <= k_d;
      i_q      <= i_d;
      pend_q   <= pend_d;
      pidx_q   <= pidx_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    op_d     = op_q;
    array_d  = array_q;
    key_d    = key_q;
    err_d    = err_q;
    k_d      = k_q;
    i_d      = i_q;
    pidx_d   = i_q;
    pend_d   = 1'b0;
    result_d = result_q;

    // A lone valid requester wins; the pointer only breaks ties.
    if (bus.req0_valid && bus.req1_valid) grant = prio_q;
    else if (bus.req1_valid)              grant = 1'b1;
    else if (bus.req0_valid)              grant = 1'b0;
    else                                  grant = prio_q;

    idle_ok = (state_q == IDLE) && !reset;
    accept  = idle_ok && (grant ? bus.req1_valid : bus.req0_valid);
    bad_req = (array_q >= NARRAYS_W) || (op_q == 2'd3);

    bus.req0_ready = idle_ok && !grant;
    bus.req1_ready = idle_ok && grant;
    bus.size_array = array_q;
    bus.heap_rd    = 1'b0;
    bus.heap_addr  = array_q * NAREA_W + i_q;
    bus.res_valid  = (state_q == DONE);
    bus.res_data   = result_q;
    bus.res_owner  = owner_q;
    bus.res_error  = err_q;
    bus.busy       = (state_q != IDLE);

    // Read data lags heap_rd by one cycle, so it is scored against the index issued then.
    if (pend_q) begin
      unique case (op_q)
        2'd0: if (bus.heap_data == key_q) result_d = pidx_q + 1'b1;
        2'd1: if (bus.heap_data < key_q)  result_d = result_q + 1'b1;
        2'd2: if (bus.heap_data > key_q)  result_d = result_q + 1'b1;
        default: ;
      endcase
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d  = grant;
          prio_d   = ~grant;
          op_d     = grant ? bus.req1_op    : bus.req0_op;
          array_d  = grant ? bus.req1_array : bus.req0_array;
          key_d    = grant ? bus.req1_key   : bus.req0_key;
          err_d    = 1'b0;
          result_d = '0;
          state_d  = SIZE;
        end
      end
      SIZE: begin
        i_d   = '0;
        err_d = bad_req;
        if (bad_req)                      k_d = '0;
        else if (bus.size_data < NAREA_W) k_d = bus.size_data;
        else                              k_d = NAREA_W;
        state_d = (bad_req || bus.size_data == '0) ? FLUSH : SCAN;
      end
      SCAN: begin
        bus.heap_rd = 1'b1;
        pend_d      = 1'b1;
        i_d         = i_q + 1'b1;
        if (i_q + 1'b1 == k_q) state_d = FLUSH;
      end
      FLUSH: state_d = DONE;
      DONE:  if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_array_scan_sequencer.sv
// Directed bench for array_scan_sequencer with hand-computed results, latencies and addresses.
module tb_array_scan_sequencer;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   n_fail;

  array_scan_sequencer_if #(.W(12)) bus ();

  array_scan_sequencer #(
    .MemoryElementWidth(12),
    .NArea(3),
    .NArrays(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  logic [11:0] mem [0:15];
  logic [11:0] sz  [0:3];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb bus.size_data = (bus.size_array < 12'd4) ? sz[bus.size_array[1:0]] : 12'd7;

  always @(posedge clock)
    if (bus.heap_rd) bus.heap_data <= (bus.heap_addr < 12'd16) ? mem[bus.heap_addr[3:0]] : 12'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [1:0] op,
                         input logic [11:0] arr, input logic [11:0] key);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_array = arr; bus.req0_key = key;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_array = arr; bus.req1_key = key;
    end
  endtask

  task automatic run_req(input int n, input logic [1:0] op, input logic [11:0] arr,
                         input logic [11:0] key, input int exp_data, input int exp_err,
                         input int exp_k, input int hold);
    int t;
    int cyc;
    int reads;
    @(negedge clock);
    set_req(n, 1'b1, op, arr, key);
    #1;
    t = 0;
    while (!(n == 0 ? bus.req0_ready : bus.req1_ready) && t < 20) begin
      @(negedge clock); #1; t++;
    end
    check("ready", (n == 0 ? bus.req0_ready : bus.req1_ready), 1);
    @(negedge clock);
    set_req(n, 1'b0, 2'd0, 12'd0, 12'd0);
    cyc = 1;
    reads = 0;
    while (!bus.res_valid && cyc < 40) begin
      if (bus.heap_rd) begin
        check("heap_addr", bus.heap_addr, arr * 3 + reads);
        reads++;
      end
      @(negedge clock);
      cyc++;
    end
    check("latency", cyc, exp_k + 3);
    check("heap_reads", reads, exp_k);
    check("res_data", bus.res_data, exp_data);
    check("res_error", bus.res_error, exp_err);
    check("res_owner", bus.res_owner, n);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("hold_valid", bus.res_valid, 1);
      check("hold_data", bus.res_data, exp_data);
    end
    bus.res_ready = 1'b1;
    @(negedge clock);
    bus.res_ready = 1'b0;
    check("idle_after_res", bus.busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int reads;
    int t;
    n_checks = 0; n_pass = 0; n_fail = 0;
    for (int a = 0; a < 16; a++) mem[a] = 12'd0;
    mem[0] = 12'd10; mem[1] = 12'd20; mem[2] = 12'd30;
    mem[3] = 12'd5;  mem[4] = 12'd6;  mem[5] = 12'd7;
    sz[0] = 12'd3; sz[1] = 12'd7; sz[2] = 12'd0; sz[3] = 12'd3;
    bus.res_ready = 1'b0;
    set_req(0, 1'b1, 2'd0, 12'd0, 12'd0);
    set_req(1, 1'b1, 2'd0, 12'd0, 12'd0);

    // Reset state, with both requesters already asserting valid
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_owner", bus.res_owner, 0);
    check("rst_error", bus.res_error, 0);
    check("rst_heap_rd", bus.heap_rd, 0);
    set_req(0, 1'b0, 2'd0, 12'd0, 12'd0);
    set_req(1, 1'b0, 2'd0, 12'd0, 12'd0);
    reset = 1'b0;

    // arrayIndex, arrayCountLess, arrayCountGreater on array 0 = [10,20,30]
    run_req(0, 2'd0, 12'd0, 12'd30, 3, 0, 3, 0);
    run_req(0, 2'd0, 12'd0, 12'd20, 2, 0, 3, 0);
    run_req(0, 2'd0, 12'd0, 12'd10, 1, 0, 3, 0);
    run_req(0, 2'd0, 12'd0, 12'd15, 0, 0, 3, 0);
    run_req(0, 2'd1, 12'd0, 12'd35, 3, 0, 3, 0);
    run_req(0, 2'd1, 12'd0, 12'd25, 2, 0, 3, 0);
    run_req(0, 2'd1, 12'd0, 12'd15, 1, 0, 3, 0);
    run_req(0, 2'd1, 12'd0, 12'd5,  0, 0, 3, 0);
    run_req(0, 2'd2, 12'd0, 12'd35, 0, 0, 3, 0);
    run_req(0, 2'd2, 12'd0, 12'd25, 1, 0, 3, 0);
    run_req(0, 2'd2, 12'd0, 12'd15, 2, 0, 3, 0);
    run_req(0, 2'd2, 12'd0, 12'd5,  3, 0, 3, 0);

    // Round-robin with both requesters valid continuously from reset
    set_req(0, 1'b1, 2'd0, 12'd0, 12'd20);
    set_req(1, 1'b1, 2'd1, 12'd0, 12'd35);
    do_reset();
    #1;
    check("rr_first_ready0", bus.req0_ready, 1);
    check("rr_first_ready1", bus.req1_ready, 0);
    bus.res_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      reads = 0;
      t = 0;
      while (!bus.res_valid && t < 40) begin
        if (bus.heap_rd) begin
          check("rr_heap_addr", bus.heap_addr, reads);
          reads++;
        end
        @(negedge clock);
        t++;
      end
      check("rr_reads", reads, 3);
      check("rr_owner", bus.res_owner, s % 2);
      check("rr_data", bus.res_data, (s % 2 == 0) ? 2 : 3);
      @(negedge clock);
    end
    bus.res_ready = 1'b0;
    set_req(0, 1'b0, 2'd0, 12'd0, 12'd0);
    set_req(1, 1'b0, 2'd0, 12'd0, 12'd0);
    @(negedge clock);
    @(negedge clock);

    // Zero-length scans: empty array, out-of-range array, reserved op
    run_req(0, 2'd1, 12'd2, 12'd99, 0, 0, 0, 0);
    run_req(1, 2'd2, 12'd4, 12'd0,  0, 1, 0, 0);
    run_req(0, 2'd3, 12'd0, 12'd30, 0, 1, 0, 0);

    // Size clamped to NArea, result held while res_ready stays low
    run_req(1, 2'd1, 12'd1, 12'd7, 2, 0, 3, 5);
    run_req(1, 2'd0, 12'd1, 12'd6, 2, 0, 3, 0);

    // Reset mid-scan abandons the transaction
    @(negedge clock);
    set_req(0, 1'b1, 2'd0, 12'd0, 12'd30);
    @(negedge clock);
    set_req(0, 1'b0, 2'd0, 12'd0, 12'd0);
    @(negedge clock);
    @(negedge clock);
    check("mid_scan_rd", bus.heap_rd, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_heap_rd", bus.heap_rd, 0);
    check("abort_res_valid", bus.res_valid, 0);
    check("abort_busy", bus.busy, 0);
    run_req(0, 2'd0, 12'd0, 12'd20, 2, 0, 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
